// File: rtl/ir_prefetch_queue_if.sv
// Handshake and decoded-field bundle between the W bus / controller and the
// instruction prefetch queue.
interface ir_prefetch_queue_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] DATA;
    logic                  IR_in;
    logic                  advance;
    logic                  flush;
    logic                  ir_ready;
    logic                  ir_valid;
    logic [DATA_WIDTH-1:0] REG_OUT_IR;
    logic [3:0]            opcode_out;
    logic [2:0]            rd_out;
    logic [2:0]            rs_1;
    logic [2:0]            rs_2;
    logic                  S;
    logic [1:0]            shift;
    logic [CW-1:0]         count;
    logic                  overflow;

    modport master (
        output DATA, IR_in, advance, flush,
        input  ir_ready, ir_valid, REG_OUT_IR, opcode_out, rd_out,
               rs_1, rs_2, S, shift, count, overflow
    );

    modport slave (
        input  DATA, IR_in, advance, flush,
        output ir_ready, ir_valid, REG_OUT_IR, opcode_out, rd_out,
               rs_1, rs_2, S, shift, count, overflow
    );
endinterface

// File: rtl/ir_prefetch_queue.sv
// Instruction register with a DEPTH-entry prefetch FIFO; the oldest word and
// its decoded fields are presented until consumed, and flush empties the queue.
module ir_prefetch_queue #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    ir_prefetch_queue_if.slave        bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  overflow_q, overflow_d;

    logic                  empty, full, push, pop, wr_en;
    logic [DATA_WIDTH-1:0] head;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == FULL_CNT);
        pop        = bus.advance && !empty;
        // A full queue still accepts a push when the head is leaving this cycle.
        push       = bus.IR_in && (!full || pop);
        wr_en      = push && !bus.flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (bus.IR_in && !push) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not cleared by reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (reset && wr_en) mem_q[wr_ptr_q] <= bus.DATA;
    end

    always_comb begin
        head           = empty ? '0 : mem_q[rd_ptr_q];
        bus.REG_OUT_IR = head;
        bus.opcode_out = head[15:12];
        bus.rd_out     = head[11:9];
        bus.rs_1       = head[8:6];
        bus.rs_2       = head[5:3];
        bus.S          = head[2];
        bus.shift      = head[1:0];
        bus.count      = count_q;
        bus.overflow   = overflow_q;
        bus.ir_valid   = !empty;
        bus.ir_ready   = !full;
    end
endmodule

// File: doc/ir_prefetch_queue.md
# ir_prefetch_queue

Parametrised instruction register with a small prefetch FIFO. It sits between the W bus and the control unit. It captures instruction words from the bus on a load strobe and holds up to DEPTH of them in order. It presents the oldest word, and its decoded fields, to the controller until that word is consumed. Branches discard queued words with a single-cycle flush.

## Interface
Parameters:
- DATA_WIDTH, 16, instruction word width; must be ≥ 16. Fields are decoded from bits [15:0]; upper bits pass through on REG_OUT_IR only.
- DEPTH, 4, queue entries; power of two, ≥ 2.
- CW, $clog2(DEPTH+1), width of count (localparam).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-low reset.
- DATA  in  DATA_WIDTH  W bus value.
- IR_in  in  1  push strobe; DATA is sampled on the clock edge where it is high.
- advance  in  1  pop the head entry (controller consumed it).
- flush  in  1  discard all entries.
- ir_ready  out  1  queue can accept a push this cycle (count < DEPTH).
- ir_valid  out  1  head entry valid (count > 0).
- REG_OUT_IR  out  DATA_WIDTH  head word; 0 when empty.
- opcode_out  out  4  head[15:12].
- rd_out  out  3  head[11:9].
- rs_1  out  3  head[8:6].
- rs_2  out  3  head[5:3].
- S  out  1  head[2].
- shift  out  2  head[1:0].
- count  out  CW  number of valid entries.
- overflow  out  1  sticky flag: a push was dropped.

## Operation
- Storage is a DEPTH-entry register array with a write pointer, a read pointer and a count, all registered. Pointers wrap modulo DEPTH.
- The head word and decoded fields are a combinational mux of stored data by the read pointer. There is no combinational path from DATA, IR_in or advance to any output.
- When empty (count = 0), REG_OUT_IR and all decoded fields are forced to 0.
- Per-cycle priority, evaluated in this order:
  - Reset low: all pointers, count and overflow cleared; stored data need not clear.
  - flush high: pointers and count go to 0 and overflow clears. A same-cycle IR_in or advance is discarded.
  - Otherwise push = IR_in and (count < DEPTH, or advance with count > 0).
  - Otherwise pop = advance and count > 0.
  - push and pop together: both pointers advance and count is unchanged. This includes when the queue is full, where the new word occupies the slot just freed.
  - advance when empty: ignored; a same-cycle push is still accepted.
  - IR_in when full without advance: word dropped, overflow set to 1, no other state changes.
- overflow stays at 1 until flush or reset.
- count never exceeds DEPTH and never underflows.

## Timing
- Reset values: ir_ready=1, ir_valid=0, count=0, overflow=0, REG_OUT_IR=0, all decoded fields 0.
- Push-to-output latency is 1 cycle. A word pushed into an empty queue appears on REG_OUT_IR, and ir_valid rises, after that edge.
- Pop latency is 1 cycle. After the edge with advance high, the next-oldest word is at the head, or the outputs go to 0 if the queue became empty.
- ir_ready and ir_valid follow count with no extra delay.
- Flush takes effect at the edge where it is sampled: the next cycle shows ir_valid=0, count=0 and ir_ready=1.
- Reset asserted mid-operation behaves like flush with priority over every other input.
- Back-to-back IR_in on every cycle fills the queue in DEPTH cycles; ir_ready drops after the DEPTH-th push.

## Test plan
- Reset and single push: hold reset low 2 cycles, release, push 16'hAAAA -> next cycle ir_valid=1, count=1, REG_OUT_IR=16'hAAAA, opcode_out=4'hA, rd_out=5, rs_1=2, rs_2=5, S=0, shift=2.
- FIFO order: push 16'hAAAA then 16'hFFFF, then advance once -> head=16'hFFFF with opcode_out=4'hF, rd_out=7, rs_1=7, rs_2=7, S=1, shift=3. Advance again -> ir_valid=0 and all outputs 0.
- Fill and overflow: with DEPTH=4, push 16'h0001..16'h0004 -> count=4, ir_ready=0. Push 16'h0005 -> dropped, overflow=1, head still 16'h0001.
- Full push+pop: queue full holding 16'h0001..16'h0004; IR_in=1 with DATA=16'h0005 and advance=1 in the same cycle -> count stays 4, head=16'h0002. Draining yields 16'h0002, 16'h0003, 16'h0004, 16'h0005, with read-pointer wrap-around.
- Flush priority: 3 entries queued and overflow=1; flush=1 with IR_in=1 and advance=1 in the same cycle -> next cycle count=0, overflow=0, ir_valid=0, pushed word absent.
- Empty corner and reset mid-run: when empty, assert advance+IR_in with 16'h1234 -> count=1, head=16'h1234. Then drive reset low while 2 entries are queued -> next cycle all outputs at reset values.
